// File: rtl/fifo_pop_arbiter.sv
`timescale 1ns/1ps
// Round-robin pop scheduler sharing one pipelined FIFO between NUM_REQ requesters, with response tagging and flush/drain.
// Optional FIFO_POP_ARB_STATS_EN builds saturating per-requester grant counters read through stat_sel/stat_cnt.
module fifo_pop_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 11,
  parameter int PIPE_LAT   = 3,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [FIFO_WIDTH-1:0] fifo_pop_data,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [FIFO_WIDTH-1:0] rsp_data,
  output logic                  flush_done,
  output logic                  busy,
  input  logic [ID_W-1:0]       stat_sel,
  output logic [15:0]           stat_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     winner;
  logic [ID_W:0]       idx;
  logic                found;
  logic                grant_ok;
  logic [PIPE_LAT-1:0] vld_q;
  logic [ID_W-1:0]     id_q [PIPE_LAT];

  // First asserted request at or above the pointer, wrapping at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant_ok = (state_q == S_RUN) && en && !flush && !fifo_empty && found;
    gnt      = '0;
    rr_ptr_d = rr_ptr_q;
    if (grant_ok) begin
      gnt[winner] = 1'b1;
      rr_ptr_d    = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end
    fifo_pop = grant_ok;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush)   state_d = S_DRAIN;
        else if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (flush)    state_d = S_DRAIN;
        else if (!en) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // A flush arriving here is absorbed; completion only waits for the pipeline to empty.
        if (!busy) begin
          flush_done = 1'b1;
          state_d    = en ? S_RUN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Tag pipeline mirrors the FIFO's post-pop latency so each word returns with its requester ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) id_q[i] <= '0;
    end else begin
      vld_q[0] <= fifo_pop;
      id_q[0]  <= fifo_pop ? winner : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign busy      = |vld_q;
  assign rsp_valid = vld_q[PIPE_LAT-1];
  assign rsp_id    = id_q[PIPE_LAT-1];
  assign rsp_data  = fifo_pop_data;

`ifdef FIFO_POP_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] stat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      stat_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush_done)                         cnt_q[i] <= '0;
        else if (gnt[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
      stat_cnt_q <= (int'(stat_sel) < NUM_REQ) ? cnt_q[stat_sel] : '0;
    end
  end

  assign stat_cnt = stat_cnt_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
`timescale 1ns/1ps
// Bench for fifo_pop_arbiter: fixed vector table, hand-written multi-cycle corners, then randomized
// traffic compared against a queue-based model of grants, responses and drain behaviour.
module tb_fifo_pop_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int FIFO_WIDTH = 11;
  localparam int PIPE_LAT   = 3;
  localparam int ID_W       = $clog2(NUM_REQ);
`ifdef FIFO_POP_ARB_STATS_EN
  localparam int STAT5 = 5;
`else
  localparam int STAT5 = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0, flush = 1'b0, fifo_empty = 1'b1;
  logic [NUM_REQ-1:0]    req = '0, gnt;
  logic                  fifo_pop, rsp_valid, flush_done, busy;
  logic [FIFO_WIDTH-1:0] fifo_pop_data = '0, rsp_data;
  logic [ID_W-1:0]       rsp_id, stat_sel = '0;
  logic [15:0]           stat_cnt;

  always #5 clk = ~clk;

  fifo_pop_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .req(req), .gnt(gnt),
    .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .fifo_pop_data(fifo_pop_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .flush_done(flush_done), .busy(busy), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int                  m_mode;  // 0 idle, 1 run, 2 drain
  int                  m_ptr, cyc, m_win, m_stat;
  int                  cnt [NUM_REQ];
  int                  due_q [$];
  logic [ID_W-1:0]     exp_q [$];
  bit                  m_busy, m_rv, m_fd;
  logic [ID_W-1:0]     m_rid;

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; cyc = 0; m_stat = 0;
    due_q.delete();
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
  endtask

  task automatic model_eval();
    while (due_q.size() != 0 && due_q[0] < cyc) begin
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
    m_busy = (due_q.size() != 0);
    m_rv   = 1'b0;
    m_rid  = '0;
    if (m_busy && due_q[0] == cyc) begin
      m_rv  = 1'b1;
      m_rid = exp_q[0];
    end
    m_fd  = (m_mode == 2) && !m_busy;
    m_win = -1;
    if (m_mode == 1 && en && !flush && !fifo_empty)
      for (int k = 0; k < NUM_REQ; k++)
        if (m_win < 0 && req[(m_ptr + k) % NUM_REQ]) m_win = (m_ptr + k) % NUM_REQ;
  endtask

  task automatic model_commit();
    if (m_win >= 0) begin
      due_q.push_back(cyc + PIPE_LAT);
      exp_q.push_back(ID_W'(m_win));
      m_ptr = (m_win + 1) % NUM_REQ;
    end
    m_stat = (int'(stat_sel) < NUM_REQ) ? cnt[stat_sel] : 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m_fd)                          cnt[i] = 0;
      else if (i == m_win && cnt[i] < 65535) cnt[i]++;
    end
    case (m_mode)
      0: if (flush) m_mode = 2; else if (en) m_mode = 1;
      1: if (flush) m_mode = 2; else if (!en) m_mode = 0;
      default: if (m_fd) m_mode = en ? 1 : 0;
    endcase
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; req = '0; fifo_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic               en, flush;
    logic [NUM_REQ-1:0] req;
    logic               empty;
    logic [NUM_REQ-1:0] gnt;
    logic               rv;
    logic [ID_W-1:0]    rid;
    logic               fd, busy;
  } vec_t;

  vec_t vecs [21];

  initial begin
    bit got;
    logic [NUM_REQ-1:0] eg;

    //           en fl req     emp gnt     rv rid fd busy
    vecs[0]  = '{1, 0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 4'b1111, 0, 4'b0001, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 4'b1111, 0, 4'b0010, 0, 0, 0, 1};
    vecs[3]  = '{1, 0, 4'b1111, 0, 4'b0100, 0, 0, 0, 1};
    vecs[4]  = '{1, 0, 4'b1111, 0, 4'b1000, 1, 0, 0, 1};
    vecs[5]  = '{1, 0, 4'b1111, 0, 4'b0001, 1, 1, 0, 1};
    vecs[6]  = '{1, 0, 4'b0100, 1, 4'b0000, 1, 2, 0, 1};
    vecs[7]  = '{1, 0, 4'b0100, 0, 4'b0100, 1, 3, 0, 1};
    vecs[8]  = '{1, 0, 4'b0000, 0, 4'b0000, 1, 0, 0, 1};
    vecs[9]  = '{1, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 1};
    vecs[10] = '{1, 0, 4'b1001, 0, 4'b1000, 1, 2, 0, 1};
    vecs[11] = '{1, 0, 4'b1001, 0, 4'b0001, 0, 0, 0, 1};
    vecs[12] = '{1, 1, 4'b1001, 0, 4'b0000, 0, 0, 0, 1};
    vecs[13] = '{1, 0, 4'b1001, 0, 4'b0000, 1, 3, 0, 1};
    vecs[14] = '{1, 0, 4'b1001, 0, 4'b0000, 1, 0, 0, 1};
    vecs[15] = '{1, 0, 4'b1001, 0, 4'b0000, 0, 0, 1, 0};
    vecs[16] = '{1, 0, 4'b1001, 0, 4'b1000, 0, 0, 0, 0};
    vecs[17] = '{0, 0, 4'b1001, 0, 4'b0000, 0, 0, 0, 1};
    vecs[18] = '{0, 0, 4'b1001, 0, 4'b0000, 0, 0, 0, 1};
    vecs[19] = '{0, 0, 4'b1001, 0, 4'b0000, 1, 3, 0, 1};
    vecs[20] = '{0, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0};

    // Reset values, with inputs that would otherwise grant.
    rst = 1'b1; en = 1'b1; req = '1; fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_pop", 32'(fifo_pop), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_flush_done", 32'(flush_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stat_cnt", 32'(stat_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      en = vecs[i].en; flush = vecs[i].flush; req = vecs[i].req; fifo_empty = vecs[i].empty;
      fifo_pop_data = FIFO_WIDTH'($urandom);
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_pop", i), 32'(fifo_pop), 32'(vecs[i].gnt != '0));
      check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rv));
      if (vecs[i].rv) check($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].rid));
      check($sformatf("vec%0d_flush_done", i), 32'(flush_done), 32'(vecs[i].fd));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(fifo_pop_data));
      tick();
    end

    // Flush with nothing in flight and en=0: one-cycle flush_done, then idle.
    en = 1'b0; flush = 1'b1; req = '1; fifo_empty = 1'b0;
    @(negedge clk);
    check("fl0_gnt", 32'(gnt), 0);
    check("fl0_done", 32'(flush_done), 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("fl1_done", 32'(flush_done), 1);
    check("fl1_gnt", 32'(gnt), 0);
    tick();
    @(negedge clk);
    check("fl2_done", 32'(flush_done), 0);
    check("fl2_gnt", 32'(gnt), 0);
    tick();

    // Five grants to requester 2, registered stat read, clear on drain completion.
    en = 1'b1; req = '0; stat_sel = ID_W'(2);
    @(negedge clk);
    tick();
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("st_gnt", 32'(gnt), 32'(4'b0100));
      tick();
    end
    req = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("st_cnt5", 32'(stat_cnt), 32'(STAT5));
    tick();
    flush = 1'b1;
    @(negedge clk);
    tick();
    flush = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (flush_done) got = 1'b1;
      else tick();
    end
    check("st_flush_done_seen", 32'(got), 1);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    check("st_cnt_cleared", 32'(stat_cnt), 0);
    tick();

    // Async reset one cycle after a pop drops the in-flight tag.
    req = 4'b0001;
    @(negedge clk);
    check("rm_gnt", 32'(gnt), 32'(4'b0001));
    tick();
    req = '0;
    rst = 1'b1;
    #1;
    check("rm_busy", 32'(busy), 0);
    check("rm_rsp_valid", 32'(rsp_valid), 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rm_no_rsp", 32'(rsp_valid), 0);
      tick();
    end

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      en            = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 24) == 0);
      req           = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      fifo_empty    = ($urandom_range(0, 3) == 0);
      stat_sel      = ID_W'($urandom_range(0, NUM_REQ - 1));
      fifo_pop_data = FIFO_WIDTH'($urandom);
      @(negedge clk);
      model_eval();
      eg = '0;
      if (m_win >= 0) eg[m_win] = 1'b1;
      check("rnd_gnt", 32'(gnt), 32'(eg));
      check("rnd_pop", 32'(fifo_pop), 32'(m_win >= 0));
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv) check("rnd_rsp_id", 32'(rsp_id), 32'(m_rid));
      check("rnd_rsp_data", 32'(rsp_data), 32'(fifo_pop_data));
      check("rnd_flush_done", 32'(flush_done), 32'(m_fd));
      check("rnd_busy", 32'(busy), 32'(m_busy));
`ifdef FIFO_POP_ARB_STATS_EN
      check("rnd_stat_cnt", 32'(stat_cnt), 32'(m_stat));
`else
      check("rnd_stat_cnt", 32'(stat_cnt), 0);
`endif
      model_commit();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
